// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait-state freeze with timeout, EX control-transfer
// flush and ID/EX load-use bubble, plus debug stall counter and sticky memory-error flag.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ID_inst,
    input  logic             ID_regread1,
    input  logic             ID_regread2,
    input  logic [31:0]      EX_inst,
    input  logic             EX_memread,
    input  logic             EX_regwrite,
    input  logic             EX_take,
    input  logic             MEM_memread,
    input  logic             MEM_memwrite,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WCNT_W = 8;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_d;
    logic                err_d;
    logic                freeze;
    logic                mem_req;
    logic                load_use;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic [REG_W-1:0]    ex_ld;
    logic                unused_inst_bits;

    assign unused_inst_bits = ^{ID_inst[31:26], ID_inst[15:0], EX_inst[31:21], EX_inst[15:0]};

    assign mem_req = MEM_memread | MEM_memwrite;
    assign id_rs   = ID_inst[25:21];
    assign id_rt   = ID_inst[20:16];
    assign ex_ld   = EX_inst[20:16];

    // Load in EX whose destination is a live source of the ID instruction ($0 never hazards)
    assign load_use = EX_memread & EX_regwrite & (ex_ld != REG_W'(0)) &
                      ((ID_regread1 & (id_rs == ex_ld)) | (ID_regread2 & (id_rt == ex_ld)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= WCNT_W'(0);
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            mem_err <= err_d;
        end
    end

    // Next state and stall/flush decode; the cycle memory completes in WAIT decodes as RUN
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        err_d        = mem_err;
        freeze       = 1'b0;
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WCNT_W'(1);
                    freeze  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = WCNT_W'(0);
                end else begin
                    freeze = 1'b1;
                    if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = WCNT_W'(0);
            end
        endcase

        if (!rst) begin
            if (freeze) begin
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (EX_take) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    // Saturating count of PC-hold cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= CNT_W'(0);
        end else if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Generates the stall and flush controls consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers of the 5-stage MIPS core.
- Detects three conditions and resolves them in priority order:
  - data-memory wait states (FSM with timeout),
  - control transfers resolved in EX,
  - load-use hazards between the ID and EX stages.
- Also keeps a saturating stall-cycle counter and a sticky memory-error flag for debug.

Parameters:
- MEM_TIMEOUT, 15: max consecutive wait cycles before declaring a memory error; legal range 1..255.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ID_inst  in  32  instruction in ID; rs = [25:21], rt = [20:16]
- ID_regread1  in  1  ID instruction reads rs
- ID_regread2  in  1  ID instruction reads rt
- EX_inst  in  32  instruction in EX
- EX_memread  in  1  EX instruction is a load
- EX_regwrite  in  1  EX instruction writes a register
- EX_take  in  1  branch taken / jump / jumpr resolved in EX this cycle
- MEM_memread  in  1  MEM-stage load
- MEM_memwrite  in  1  MEM-stage store
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF_ID
- IF_ID_flush  out  1  clear IF_ID to NOP
- ID_EX_stall  out  1  hold ID_EX
- ID_EX_flush  out  1  load bubble (NOP, all controls 0) into ID_EX
- EX_MEM_stall  out  1  hold EX_MEM
- MEM_WB_flush  out  1  insert bubble into MEM_WB
- mem_err  out  1  sticky: memory timeout occurred
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock and reset: one clock clk; synchronous active-high reset rst.
- Reset: FSM -> RUN, wait counter = 0, mem_err = 0, stall_cycles = 0. While rst = 1, all stall/flush outputs = 0. Reset mid-WAIT or mid-ERR returns the FSM to RUN on the next edge.
- Output timing: stall/flush outputs are combinational from FSM state and current inputs (zero latency), so the pipeline registers act on them at the same edge. mem_err and stall_cycles are registered.
- mem_req = MEM_memread | MEM_memwrite.
- FSM states: RUN, WAIT, ERR.
  - RUN -> WAIT when mem_req & !dmem_ready; wait counter <= 1.
  - WAIT, dmem_ready = 1 -> RUN; counter <= 0.
  - WAIT, dmem_ready = 0 and counter == MEM_TIMEOUT -> ERR; mem_err <= 1.
  - WAIT, otherwise: counter <= counter + 1.
  - ERR stays until rst.
- Freeze condition (highest priority): FSM in WAIT or ERR, or (RUN & mem_req & !dmem_ready).
  - pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall = 1.
  - MEM_WB_flush = 1.
  - IF_ID_flush and ID_EX_flush forced 0, because a pipeline register gives flush priority over stall.
  - EX_take and load-use are ignored during freeze; they are re-evaluated when the freeze ends.
- The cycle dmem_ready = 1 arrives in WAIT: outputs follow the RUN rules for that cycle.
- Control flush (RUN, not frozen, EX_take = 1): IF_ID_flush = 1, ID_EX_flush = 1, all stalls 0 so the PC loads the target.
- Load-use (RUN, not frozen, EX_take = 0):
  - Hazard condition: ld = EX_inst[20:16]; hazard when EX_memread & EX_regwrite & ld != 0 & ((ID_regread1 & rs == ld) | (ID_regread2 & rt == ld)).
  - Response: pc_stall = 1, IF_ID_stall = 1, ID_EX_flush = 1; all other outputs 0. Exactly one bubble per load.
- EX_take together with load-use: flush wins, because the ID instruction is wrong-path.
- Never assert stall and flush on the same register in the same cycle.
- stall_cycles: increments each cycle pc_stall = 1, holds at 2^CNT_W - 1.

Test Plan:
- Load-use: EX = lw $5 (EX_inst[20:16] = 5, EX_memread = 1, EX_regwrite = 1); ID = add reading rs = 5 -> pc_stall = IF_ID_stall = ID_EX_flush = 1 for exactly 1 cycle; stall_cycles 0 -> 1. Repeat with ld = 0 -> no stall.
- Taken branch: EX_take = 1, no mem_req -> IF_ID_flush = ID_EX_flush = 1, all stalls 0 for 1 cycle. Same cycle with a load-use match -> still flush-only, pc_stall = 0.
- Memory wait: MEM_memread = 1, dmem_ready low for 3 cycles then high -> all four stalls and MEM_WB_flush = 1 for 3 cycles, 0 on the 4th; FSM back in RUN; stall_cycles += 3.
- Timeout: MEM_TIMEOUT = 4, dmem_ready held 0 -> ERR entered after 4 WAIT cycles, mem_err = 1 and stalls held; assert rst 1 cycle -> mem_err = 0, outputs 0, FSM in RUN.
- Freeze masks flush: EX_take = 1 during WAIT -> IF_ID_flush = ID_EX_flush = 0. Once dmem_ready = 1 with EX_take still 1 -> flushes asserted that cycle.
- Saturation: CNT_W = 4, load-use stall sustained 20 cycles -> stall_cycles stops at 15.
